pwm_multi_channel: RTL and testbench
====================================

Name: pwm_multi_channel

Overview:
- Parametrised successor to the single-channel PWM block in the bridge's debug/aux path.
- Drives NUM_CH independent PWM outputs from one shared prescaler and period counter, with a per-channel duty cycle, polarity and enable.
- Supports edge-aligned and center-aligned modes.
- Configuration is double-buffered: shadow registers update only at a period boundary, so outputs are glitch-free.
- Sits behind the AXI-lite register file, which supplies configuration levels and a load strobe.

Parameters:
NUM_CH, 4, number of PWM channels
CNT_W, 8, width of period/duty/counter
PRE_W, 16, width of prescaler value

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  run counter; 0 = halt and idle outputs
prescale  input  PRE_W  tick every prescale+1 clk cycles
period  input  CNT_W  period value P (shadowed)
center_mode  input  1  0 = edge-aligned, 1 = center-aligned (shadowed)
duty  input  NUM_CH*CNT_W  channel k duty at bits [k*CNT_W +: CNT_W] (shadowed)
ch_en  input  NUM_CH  per-channel enable (shadowed)
polarity  input  NUM_CH  per-channel invert; also the idle level (shadowed)
load  input  1  1-cycle strobe requesting a shadow update
pwm_out  output  NUM_CH  registered PWM outputs
period_start  output  1  1-cycle pulse at start of each period
load_pending  output  1  shadow update requested, not yet applied
cnt  output  CNT_W  current counter value (debug)

Behaviour:
- Reset (async, rst=1): prescaler, cnt, dir(up), all shadows, load_pending, period_start and pwm_out are 0. Removal of reset is synchronous to clk.
- Prescaler: counts 0..prescale, then wraps. "tick" is high in the cycle the prescaler equals prescale. prescale=0 gives a tick every cycle. prescale is not shadowed and takes effect immediately.
- enable=0:
  - prescaler, cnt and dir are cleared every cycle; no ticks.
  - pwm_out goes to polarity_s on the next cycle.
  - A load in this state copies the inputs to the shadows on the next edge; load_pending stays 0.
- Edge mode, on tick:
  - cnt increments 0..P_s, then returns to 0.
  - Period = P_s+1 ticks.
  - Boundary = tick with cnt==P_s.
- Center mode, on tick:
  - dir up: cnt increments; at cnt==P_s, dir goes down and cnt decrements.
  - dir down: cnt decrements; at cnt==1, cnt goes to 0 and dir goes up. This tick is the boundary.
  - Sequence is 0,1..P_s,P_s-1..1; period = 2*P_s ticks.
- P_s=0 (both modes): cnt holds 0 and every tick is a boundary.
- Mode switch via shadow happens only at a boundary, so cnt=0 and dir=up at the switch.
- Compare, per channel k: raw_k = (cnt < duty_s[k]), combinational from cnt and the shadows.
  - duty_s=0 gives constant 0.
  - duty_s>P_s gives constant 1 in both modes.
- Output, registered with 1 clk latency after cnt: pwm_out[k] = ch_en_s[k] ? raw_k ^ polarity_s[k] : polarity_s[k].
- Shadow update:
  - load sets load_pending.
  - On a boundary tick with (load_pending | load), all shadows take the current inputs and load_pending clears.
  - The new values govern cnt=0 of the new period onward.
  - load coinciding with a boundary applies immediately; pending is not left set.
  - Repeated loads before a boundary collapse into one update using the inputs present at the boundary.
- period_start: registered; high for exactly one clk in the cycle after each boundary tick, i.e. while cnt first reads 0 of the new period. Never asserted while enable=0.
- enable 0→1: the first period starts at cnt=0. No period_start pulse for that first start.
- Reset mid-operation: everything returns to reset values immediately; pending loads are discarded.

Test Plan:
- Edge mode: prescale=0, P=9, duty0=3, ch_en=1, pol=0, load, enable → pwm_out[0] high 3 of every 10 clks; period_start every 10 clks.
- Bounds: duty=0 gives pwm_out=0 constant; duty=10 with P=9 gives constant 1; P=0 with duty=1 gives constant 1 and period_start every tick.
- Center mode: P=4, duty=2 → cnt sequence 0,1,2,3,4,3,2,1 repeating; output high at cnt 0,1,1 (3 of 8 ticks), symmetric about cnt=4.
- Shadow: mid-period write duty 3→7 plus load → load_pending=1, and the output is unchanged until the next period_start; then 7 high cycles and load_pending=0. A load on the boundary cycle applies with no pending left.
- Prescale=3, P=9, duty=5 → 20 clks high per 40-clk period. Polarity=1 with ch_en=0 → constant 1. enable=0 → all outputs go to polarity within 1 clk and cnt=0.
- Assert rst mid-period with a load pending → all outputs, cnt and load_pending are 0 immediately. After release plus load and enable, operation restarts from cnt=0.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared prescaler and period counter, per-channel duty,
// polarity and enable, edge- or center-aligned counting, double-buffered configuration.
module pwm_multi_channel #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PRE_W-1:0]        prescale,
  input  logic [CNT_W-1:0]        period,
  input  logic                    center_mode,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       polarity,
  input  logic                    load,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start,
  output logic                    load_pending,
  output logic [CNT_W-1:0]        cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  typedef struct packed {
    logic [CNT_W-1:0]        period;
    logic                    center;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       pol;
  } cfg_t;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dir_e              dir_q, dir_d;
  cfg_t              cfg_q, cfg_d, cfg_in;
  logic              load_pending_q, load_pending_d;
  logic              period_start_q, period_start_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] raw;
  logic              tick, boundary, apply;

  assign cfg_in = '{period: period, center: center_mode, duty: duty,
                    ch_en: ch_en, pol: polarity};

  // >= rather than == so that shrinking prescale on the fly wraps at once instead of
  // running the prescaler all the way round.
  assign tick = enable && (pre_q >= prescale);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    boundary = 1'b0;
    if (tick) begin
      if (cfg_q.period == '0)
        boundary = 1'b1;
      else if (!cfg_q.center)
        boundary = (cnt_q == cfg_q.period);
      else
        boundary = (cnt_q == CNT_ONE) && ((dir_q == DIR_DOWN) || (cfg_q.period == CNT_ONE));
    end
  end

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable) begin
      pre_d = '0;
      cnt_d = '0;
      dir_d = DIR_UP;
    end else begin
      if (tick) pre_d = '0;
      if (boundary) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else if (tick) begin
        if (!cfg_q.center) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (dir_q == DIR_UP) begin
          if (cnt_q == cfg_q.period) begin
            cnt_d = cnt_q - CNT_ONE;
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end
  end

  // While halted there is no boundary to wait for, so a load copies straight through.
  always_comb begin
    apply          = (!enable && load) || (boundary && (load_pending_q || load));
    cfg_d          = apply ? cfg_in : cfg_q;
    load_pending_d = apply ? 1'b0 : (load | load_pending_q);
    period_start_d = boundary;
  end

  always_comb begin
    raw   = '0;
    pwm_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      raw[k] = (cnt_q < cfg_q.duty[k*CNT_W +: CNT_W]);
      if (enable && cfg_q.ch_en[k])
        pwm_d[k] = raw[k] ^ cfg_q.pol[k];
      else
        pwm_d[k] = cfg_q.pol[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments only, so every flop samples
    // the values from before the edge regardless of statement order.
    if (rst) begin
      pre_q          <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      cfg_q          <= '0;
      load_pending_q <= 1'b0;
      period_start_q <= 1'b0;
      pwm_q          <= '0;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      cfg_q          <= cfg_d;
      load_pending_q <= load_pending_d;
      period_start_q <= period_start_d;
      pwm_q          <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign load_pending = load_pending_q;
  assign cnt          = cnt_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: edge/center counting, duty bounds, shadow loads,
// prescaling, polarity idle levels and mid-run reset.
module tb_pwm_multi_channel;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int PRE_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic [PRE_W-1:0]        prescale;
  logic [CNT_W-1:0]        period;
  logic                    center_mode;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       polarity;
  logic                    load;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    period_start;
  logic                    load_pending;
  logic [CNT_W-1:0]        cnt;

  int vectors     = 0;
  int miscompares = 0;
  int hc [NUM_CH];
  int psc;

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .prescale(prescale), .period(period),
    .center_mode(center_mode), .duty(duty), .ch_en(ch_en), .polarity(polarity),
    .load(load), .pwm_out(pwm_out), .period_start(period_start),
    .load_pending(load_pending), .cnt(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Counts high samples per channel and period_start pulses over n cycles.
  task automatic count_win(input int n);
    for (int k = 0; k < NUM_CH; k++) hc[k] = 0;
    psc = 0;
    for (int i = 0; i < n; i++) begin
      step();
      for (int k = 0; k < NUM_CH; k++) hc[k] += int'(pwm_out[k]);
      psc += int'(period_start);
    end
  endtask

  task automatic wait_ps(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (period_start) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  logic [CNT_W-1:0] exp_cnt [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1};
  logic             exp_pwm [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int hi;
    logic found;
    rst = 1'b1; enable = 1'b0; prescale = '0; period = '0; center_mode = 1'b0;
    duty = '0; ch_en = '0; polarity = '0; load = 1'b0;
    step(2);
    check("rst_pwm", pwm_out, 0);
    check("rst_cnt", cnt, 0);
    check("rst_pend", load_pending, 0);
    check("rst_ps", period_start, 0);
    rst = 1'b0;
    step();

    // Edge mode, P=9: duties 3, 0, 10, 5.
    prescale = 16'd0; period = 8'd9;
    duty = {8'd5, 8'd10, 8'd0, 8'd3}; ch_en = 4'hF; polarity = 4'h0;
    pulse_load();
    check("idle_load_pend", load_pending, 0);
    enable = 1'b1;
    step(25);
    count_win(10);
    check("edge_ch0_hi", hc[0], 3);
    check("edge_ch1_duty0", hc[1], 0);
    check("edge_ch2_duty_gt_p", hc[2], 10);
    check("edge_ch3_hi", hc[3], 5);
    check("edge_ps_cnt", psc, 1);

    wait_ps("edge_ps_seen");
    check("edge_ps_cnt0", cnt, 0);
    step();
    check("edge_pwm_n1", pwm_out[0], 1);
    step(2);
    check("edge_pwm_n3", pwm_out[0], 1);
    step();
    check("edge_pwm_n4", pwm_out[0], 0);
    check("edge_cnt_n4", cnt, 4);

    // Mid-period shadow update, duty 3 -> 7.
    step();
    duty[7:0] = 8'd7;
    pulse_load();
    check("mid_pend_set", load_pending, 1);
    hi = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (period_start) found = 1'b1;
      else hi += int'(pwm_out[0]);
    end
    check("mid_ps_seen", found, 1);
    check("mid_old_duty_tail", hi, 0);
    count_win(10);
    check("mid_new_duty_hi", hc[0], 7);
    check("mid_pend_clear", load_pending, 0);

    // Load coinciding with the boundary tick.
    step(9);
    check("bnd_cnt9", cnt, 9);
    duty[7:0] = 8'd2;
    pulse_load();
    check("bnd_ps", period_start, 1);
    check("bnd_no_pend", load_pending, 0);
    count_win(10);
    check("bnd_duty2_hi", hc[0], 2);

    // P=0, duty 1: constant high, period_start every tick.
    period = 8'd0; duty[7:0] = 8'd1;
    pulse_load();
    step(15);
    count_win(10);
    check("p0_ch0_hi", hc[0], 10);
    check("p0_ps_every", psc, 10);
    check("p0_cnt", cnt, 0);

    // Center mode, P=4, duty 2.
    period = 8'd4; center_mode = 1'b1; duty[7:0] = 8'd2;
    pulse_load();
    step(10);
    wait_ps("ctr_ps_seen");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ctr_cnt_%0d", i), cnt, exp_cnt[i]);
      check($sformatf("ctr_pwm_%0d", i), pwm_out[0], exp_pwm[i]);
      step();
    end
    check("ctr_ps_wrap", period_start, 1);
    count_win(8);
    check("ctr_hi", hc[0], 3);
    check("ctr_ps_cnt", psc, 1);

    // Prescale 3, duty 5, mixed enables and polarities loaded while halted.
    enable = 1'b0;
    step();
    check("dis_cnt", cnt, 0);
    prescale = 16'd3; period = 8'd9; center_mode = 1'b0;
    duty = {8'd5, 8'd5, 8'd5, 8'd5}; ch_en = 4'b1110; polarity = 4'b0101;
    pulse_load();
    check("dis_load_pend", load_pending, 0);
    step();
    check("dis_pwm_pol", pwm_out, 4'b0101);
    enable = 1'b1;
    step(45);
    count_win(40);
    check("pre_ch0_off_pol1", hc[0], 40);
    check("pre_ch1_hi", hc[1], 20);
    check("pre_ch2_inv_hi", hc[2], 20);
    check("pre_ch3_hi", hc[3], 20);
    check("pre_ps_cnt", psc, 1);
    enable = 1'b0;
    step();
    check("halt_pwm_pol", pwm_out, 4'b0101);
    check("halt_cnt", cnt, 0);
    check("halt_ps", period_start, 0);

    // Reset mid-period with a load pending.
    prescale = 16'd0; polarity = 4'h0; ch_en = 4'hF;
    duty = {8'd5, 8'd5, 8'd5, 8'd8};
    pulse_load();
    enable = 1'b1;
    step(4);
    pulse_load();
    check("rstm_pend_set", load_pending, 1);
    check("rstm_pwm_before", pwm_out, 4'hF);
    #2 rst = 1'b1;
    #1;
    check("rstm_pwm", pwm_out, 0);
    check("rstm_cnt", cnt, 0);
    check("rstm_pend", load_pending, 0);
    step();
    rst = 1'b0; enable = 1'b0;
    duty = {8'd0, 8'd0, 8'd0, 8'd3};
    step();
    pulse_load();
    check("rel_pend", load_pending, 0);
    enable = 1'b1;
    step();
    check("rel_cnt1", cnt, 1);
    check("rel_no_first_ps", period_start, 0);
    count_win(8);
    check("rel_no_ps_p1", psc, 0);
    check("rel_ch0_hi_p1", hc[0], 2);
    step();
    check("rel_ps_p2", period_start, 1);
    check("rel_cnt_p2", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
